lfsr_checker: RTL and testbench

- Receive-side companion to the team's 8-bit Fibonacci LFSR generator (feedback = Q[7]^Q[5]^Q[4]^Q[3], state shifts left one bit per clock).
- Consumes the generator's parallel state word, self-synchronises to it and declares lock.
- Flywheels through corrupted words, counts errors and drops lock after repeated misses.
- Sits at the far end of a link or bench path carrying the random-number stream, used for built-in self-test.

---
 rtl/lfsr_checker.sv | 137 +++++++++++++
 tb/tb_lfsr_checker.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit Fibonacci LFSR stream (taps 7,5,4,3).
// Hunts for a nonzero seed, verifies LockCount predictions, then flywheels and counts errors.
module lfsr_checker #(
    parameter int Width     = 8,
    parameter int LockCount = 4,
    parameter int LossCount = 3,
    parameter int CntWidth  = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                valid,
    input  logic [Width-1:0]    data,
    input  logic                clear_cnt,
    output logic                locked,
    output logic                err_pulse,
    output logic [CntWidth-1:0] err_count,
    output logic [Width-1:0]    expected
);

    localparam int MatchW = (LockCount < 2) ? 1 : $clog2(LockCount + 1);
    localparam int MissW  = (LossCount < 2) ? 1 : $clog2(LossCount + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [Width-1:0]    ref_reg, ref_next;
    logic [MatchW-1:0]   match_reg, match_next;
    logic [MissW-1:0]    miss_reg, miss_next;
    logic [CntWidth-1:0] cnt_reg, cnt_next;
    logic                pulse_next;
    logic                locked_reg;
    logic                pulse_reg;
    logic [Width-1:0]    expected_reg;
    logic [Width-1:0]    pred;

    function automatic logic [Width-1:0] nxt(input logic [Width-1:0] p);
        return {p[Width-2:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
    endfunction

    assign pred = nxt(ref_reg);

    always_comb begin
        state_next = state_reg;
        ref_next   = ref_reg;
        match_next = match_reg;
        miss_next  = miss_reg;
        cnt_next   = cnt_reg;
        pulse_next = 1'b0;
        if (valid) begin
            case (state_reg)
                HUNT: begin
                    // All-zero is the generator's lockup word and can never seed a lock.
                    if (data != '0) begin
                        ref_next   = data;
                        match_next = '0;
                        state_next = VERIFY;
                    end
                end
                VERIFY: begin
                    if (data == pred) begin
                        ref_next = data;
                        if (match_reg + 1'b1 == MatchW'(LockCount)) begin
                            state_next = LOCKED;
                            miss_next  = '0;
                            match_next = '0;
                        end else begin
                            match_next = match_reg + 1'b1;
                        end
                    end else if (data != '0) begin
                        ref_next   = data;
                        match_next = '0;
                    end else begin
                        state_next = HUNT;
                        match_next = '0;
                    end
                end
                LOCKED: begin
                    if (data == pred) begin
                        ref_next  = data;
                        miss_next = '0;
                    end else begin
                        // Flywheel: keep advancing our own prediction, ignore the bad word.
                        ref_next   = pred;
                        pulse_next = 1'b1;
                        if (cnt_reg != '1) begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                        if (miss_reg + 1'b1 == MissW'(LossCount)) begin
                            state_next = HUNT;
                            miss_next  = '0;
                        end else begin
                            miss_next = miss_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end
        if (clear_cnt) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg    <= HUNT;
            ref_reg      <= '0;
            match_reg    <= '0;
            miss_reg     <= '0;
            cnt_reg      <= '0;
            pulse_reg    <= 1'b0;
            locked_reg   <= 1'b0;
            expected_reg <= '0;
        end else begin
            state_reg    <= state_next;
            ref_reg      <= ref_next;
            match_reg    <= match_next;
            miss_reg     <= miss_next;
            cnt_reg      <= cnt_next;
            pulse_reg    <= pulse_next;
            locked_reg   <= (state_next == LOCKED);
            expected_reg <= nxt(ref_next);
        end
    end

    assign locked    = locked_reg;
    assign err_pulse = pulse_reg;
    assign err_count = cnt_reg;
    assign expected  = expected_reg;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, flywheel, loss, stall, clear, saturation, reset.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid;
    logic [7:0]  data;
    logic        clear_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [7:0]  expected;
    logic        s_locked;
    logic        s_err_pulse;
    logic [3:0]  s_err_count;
    logic [7:0]  s_expected;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] r;

    always #5 clk = ~clk;

    lfsr_checker dut (
        .clk(clk), .rstn(rstn), .valid(valid), .data(data), .clear_cnt(clear_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .expected(expected)
    );

    // Same stimulus, narrow counter to reach saturation quickly.
    lfsr_checker #(.CntWidth(4)) u_sat (
        .clk(clk), .rstn(rstn), .valid(valid), .data(data), .clear_cnt(clear_cnt),
        .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count), .expected(s_expected)
    );

    function automatic logic [7:0] lfsr_nxt(input logic [7:0] p);
        return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic c);
        valid     = v;
        data      = d;
        clear_cnt = c;
        @(posedge clk);
        #1;
        $display("t=%0t v=%0b d=%02h clr=%0b -> locked=%0b pulse=%0b cnt=%0d exp=%02h",
                 $time, v, d, c, locked, err_pulse, err_count, expected);
    endtask

    task automatic lock_seq();
        step(1, 8'hFF, 0); check("lock_ff", locked, 0);
        step(1, 8'hFE, 0); check("lock_fe", locked, 0);
        step(1, 8'hFC, 0); check("lock_fc", locked, 0);
        step(1, 8'hF8, 0); check("lock_f8", locked, 0);
        step(1, 8'hF0, 0); check("lock_f0", locked, 1);
        check("lock_exp", expected, 8'hE1);
    endtask

    initial begin
        rstn = 1'b0; valid = 1'b0; data = 8'h00; clear_cnt = 1'b0;
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        check("rst_locked", locked, 0);
        check("rst_pulse", err_pulse, 0);
        check("rst_cnt", err_count, 0);
        check("rst_exp", expected, 0);
        rstn = 1'b1;

        lock_seq();
        check("lock_cnt", err_count, 0);

        // Single corrupted word while locked
        step(1, 8'hE1, 0); check("e1_pulse", err_pulse, 0); check("e1_exp", expected, 8'hC2);
        step(1, 8'h00, 0); check("bad_pulse", err_pulse, 1); check("bad_cnt", err_count, 1);
        check("bad_locked", locked, 1); check("bad_exp", expected, 8'h85);
        step(1, 8'h85, 0); check("fw_pulse", err_pulse, 0); check("fw_locked", locked, 1);
        check("fw_cnt", err_count, 1); check("fw_exp", expected, 8'h0B);

        // Clear with no data, then three misses lose lock
        step(0, 8'h00, 1); check("clr_idle", err_count, 0);
        step(1, 8'h55, 0); check("loss1_cnt", err_count, 1); check("loss1_lk", locked, 1);
        check("loss1_exp", expected, 8'h17);
        step(1, 8'h55, 0); check("loss2_cnt", err_count, 2); check("loss2_lk", locked, 1);
        step(1, 8'h55, 0); check("loss3_cnt", err_count, 3); check("loss3_lk", locked, 0);
        check("loss3_pulse", err_pulse, 1);
        lock_seq();
        check("relock_cnt", err_count, 3);

        // Reset while locked
        rstn = 1'b0;
        step(1, 8'hE1, 0);
        check("mrst_locked", locked, 0); check("mrst_cnt", err_count, 0);
        check("mrst_exp", expected, 0); check("mrst_pulse", err_pulse, 0);
        rstn = 1'b1;

        // Zero word in HUNT, then VERIFY abort on zero
        step(1, 8'h00, 0); check("hunt0_lk", locked, 0); check("hunt0_exp", expected, 0);
        step(1, 8'hFF, 0);
        step(1, 8'hFE, 0);
        step(1, 8'h00, 0); check("vz_lk", locked, 0); check("vz_cnt", err_count, 0);
        check("vz_pulse", err_pulse, 0);
        step(1, 8'hF8, 0);
        step(1, 8'hF0, 0);
        step(1, 8'hE1, 0);
        step(1, 8'hC2, 0); check("reseed_lk0", locked, 0);
        step(1, 8'h85, 0); check("reseed_lk1", locked, 1); check("reseed_exp", expected, 8'h0B);

        // Stall tolerance
        for (int i = 0; i < 5; i++) step(0, 8'h00, 0);
        check("stall_lk", locked, 1); check("stall_exp", expected, 8'h0B);
        check("stall_pulse", err_pulse, 0);
        step(1, 8'h0B, 0); check("resume_pulse", err_pulse, 0); check("resume_cnt", err_count, 0);
        check("resume_exp", expected, 8'h17);

        // Clear coinciding with a mismatch
        step(1, 8'h00, 0); check("pre_clr_cnt", err_count, 1);
        step(1, 8'h00, 1); check("clrmis_cnt", err_count, 0); check("clrmis_pulse", err_pulse, 1);
        check("clrmis_lk", locked, 1); check("clrmis_exp", expected, 8'h5E);
        step(1, 8'h5E, 0); check("post_clr_pulse", err_pulse, 0);

        // 20 mismatches, each pair followed by a correct word to hold lock
        r = 8'h5E;
        for (int k = 0; k < 10; k++) begin
            step(1, 8'h00, 0); r = lfsr_nxt(r);
            step(1, 8'h00, 0); r = lfsr_nxt(r);
            if (k == 7) begin
                check("sat_at16", s_err_count, 4'hF);
                check("wide_at16", err_count, 16);
            end
            r = lfsr_nxt(r);
            step(1, r, 0);
        end
        check("sat_cnt", s_err_count, 4'hF);
        check("wide_cnt", err_count, 20);
        check("sat_lk", locked, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
